// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared external memory port.
// I-cache refills and D-cache refills/write-backs each move one block as a
// command phase followed by BLOCK_WORDS data beats. A one-cycle done pulse
// goes back to the requester that owned the transfer.
module mem_port_arbiter #(
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 16
) (
    input  logic                           i_clk,
    input  logic                           i_arst,
    input  logic                           i_icache_req,
    input  logic [ADDR_W-1:0]              i_icache_addr,
    output logic                           o_icache_rvalid,
    output logic                           o_icache_done,
    input  logic                           i_dcache_req,
    input  logic                           i_dcache_we,
    input  logic [ADDR_W-1:0]              i_dcache_addr,
    input  logic [DATA_W-1:0]              i_dcache_wdata,
    output logic                           o_dcache_rvalid,
    output logic                           o_dcache_done,
    output logic [DATA_W-1:0]              o_rdata,
    output logic [$clog2(BLOCK_WORDS)-1:0] o_beat_idx,
    output logic                           o_mem_cmd_valid,
    input  logic                           i_mem_cmd_ready,
    output logic                           o_mem_we,
    output logic [ADDR_W-1:0]              o_mem_addr,
    input  logic                           i_mem_rvalid,
    input  logic [DATA_W-1:0]              i_mem_rdata,
    output logic                           o_mem_wvalid,
    output logic [DATA_W-1:0]              o_mem_wdata,
    input  logic                           i_mem_wready
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int OFF_W = $clog2(BLOCK_WORDS * DATA_W / 8);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        READ,
        WRITE,
        RESP
    } state_t;

    state_t              state_q;
    state_t              state_d;

    // Transfer context: owner_q / last_q are 1 for the D-cache, 0 for the I-cache.
    logic                owner_q;
    logic                last_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [IDX_W-1:0]    cnt_q;

    logic                grant_valid;
    logic                grant_d;
    logic                beat_ok;

    // State register; an asynchronous reset abandons any transfer in flight.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, arbitration and all port outputs.
    always_comb begin
        state_d         = state_q;
        grant_valid     = 1'b0;
        grant_d         = 1'b0;
        beat_ok         = 1'b0;
        o_icache_rvalid = 1'b0;
        o_icache_done   = 1'b0;
        o_dcache_rvalid = 1'b0;
        o_dcache_done   = 1'b0;
        o_rdata         = '0;
        o_beat_idx      = '0;
        o_mem_cmd_valid = 1'b0;
        o_mem_we        = 1'b0;
        o_mem_wvalid    = 1'b0;
        o_mem_wdata     = '0;
        case (state_q)
            IDLE: begin
                if (i_icache_req || i_dcache_req) begin
                    grant_valid = 1'b1;
                    // D wins a tie unless it also won the previous grant.
                    grant_d     = i_dcache_req && (!i_icache_req || !last_q);
                    state_d     = CMD;
                end
            end
            CMD: begin
                o_mem_cmd_valid = 1'b1;
                o_mem_we        = we_q;
                if (i_mem_cmd_ready) begin
                    state_d = we_q ? WRITE : READ;
                end
            end
            READ: begin
                o_rdata         = i_mem_rdata;
                o_beat_idx      = cnt_q;
                o_icache_rvalid = !owner_q && i_mem_rvalid;
                o_dcache_rvalid = owner_q && i_mem_rvalid;
                beat_ok         = i_mem_rvalid;
                if (i_mem_rvalid && cnt_q == LAST_IDX) begin
                    state_d = RESP;
                end
            end
            WRITE: begin
                o_mem_wvalid = 1'b1;
                o_mem_wdata  = i_dcache_wdata;
                o_beat_idx   = cnt_q;
                beat_ok      = i_mem_wready;
                if (i_mem_wready && cnt_q == LAST_IDX) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                o_icache_done = !owner_q;
                o_dcache_done = owner_q;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Latch the winner's context on a grant and count data beats.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            if (grant_valid) begin
                owner_q <= grant_d;
                last_q  <= grant_d;
                we_q    <= grant_d && i_dcache_we;
                addr_q  <= (grant_d ? i_dcache_addr : i_icache_addr) & ALIGN_MASK;
            end
            if (state_q == CMD && i_mem_cmd_ready) begin
                cnt_q <= '0;
            end else if (beat_ok) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_mem_addr = addr_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: randomized memory timing and
// request mixes checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

    localparam int ADDR_W      = 64;
    localparam int DATA_W      = 32;
    localparam int BLOCK_WORDS = 16;

    logic               i_clk = 1'b0;
    logic               i_arst;
    logic               i_icache_req;
    logic [ADDR_W-1:0]  i_icache_addr;
    logic               o_icache_rvalid;
    logic               o_icache_done;
    logic               i_dcache_req;
    logic               i_dcache_we;
    logic [ADDR_W-1:0]  i_dcache_addr;
    logic [DATA_W-1:0]  i_dcache_wdata;
    logic               o_dcache_rvalid;
    logic               o_dcache_done;
    logic [DATA_W-1:0]  o_rdata;
    logic [3:0]         o_beat_idx;
    logic               o_mem_cmd_valid;
    logic               i_mem_cmd_ready;
    logic               o_mem_we;
    logic [ADDR_W-1:0]  o_mem_addr;
    logic               i_mem_rvalid;
    logic [DATA_W-1:0]  i_mem_rdata;
    logic               o_mem_wvalid;
    logic [DATA_W-1:0]  o_mem_wdata;
    logic               i_mem_wready;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BLOCK_WORDS)
    ) dut (
        .i_clk(i_clk), .i_arst(i_arst),
        .i_icache_req(i_icache_req), .i_icache_addr(i_icache_addr),
        .o_icache_rvalid(o_icache_rvalid), .o_icache_done(o_icache_done),
        .i_dcache_req(i_dcache_req), .i_dcache_we(i_dcache_we),
        .i_dcache_addr(i_dcache_addr), .i_dcache_wdata(i_dcache_wdata),
        .o_dcache_rvalid(o_dcache_rvalid), .o_dcache_done(o_dcache_done),
        .o_rdata(o_rdata), .o_beat_idx(o_beat_idx),
        .o_mem_cmd_valid(o_mem_cmd_valid), .i_mem_cmd_ready(i_mem_cmd_ready),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata),
        .o_mem_wvalid(o_mem_wvalid), .o_mem_wdata(o_mem_wdata),
        .i_mem_wready(i_mem_wready)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int mem_mode = 0;     // 0 always ready, 1 toggling, 2 random, 3 command held off 5 cycles
    bit m_last_d = 1'b0;  // model: 1 when the D-cache won the most recent grant

    logic [138:0] all_outs;
    assign all_outs = {o_icache_rvalid, o_icache_done, o_dcache_rvalid, o_dcache_done,
                       o_rdata, o_beat_idx, o_mem_cmd_valid, o_mem_we, o_mem_addr,
                       o_mem_wvalid, o_mem_wdata};

    function automatic logic [31:0] mem_word(input logic [63:0] a, input int b);
        return a[31:0] ^ a[63:32] ^ (32'(b) * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] wr_word(input logic [63:0] a, input logic [3:0] b);
        return ~a[31:0] + {b, b, b, b, b, b, b, b};
    endfunction

    function automatic logic [63:0] align(input logic [63:0] a);
        return a & ~64'd63;
    endfunction

    // D-cache supplies the write word for the beat the arbiter is asking for.
    assign i_dcache_wdata = wr_word(i_dcache_addr, o_beat_idx);

    // Memory responder: tracks accepted commands and serves BLOCK_WORDS beats.
    logic        m_active, m_we, p_cmd, p_cmdv, p_beat, p_we, cr, go;
    logic [63:0] m_addr, p_addr;
    int          m_beats, cmd_wait, cyc_r;
    initial begin
        i_mem_cmd_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0; i_mem_wready = 1'b0;
        m_active = 1'b0; m_we = 1'b0; m_addr = '0; m_beats = 0; cmd_wait = 0; cyc_r = 0;
        p_cmd = 1'b0; p_cmdv = 1'b0; p_beat = 1'b0; p_we = 1'b0; p_addr = '0;
        forever begin
            @(posedge i_clk); #1;
            cyc_r++;
            if (i_arst) begin
                m_active = 1'b0; m_beats = 0; cmd_wait = 0;
            end else begin
                if (p_cmd) begin
                    m_active = 1'b1; m_we = p_we; m_addr = p_addr; m_beats = 0; cmd_wait = 0;
                end else if (p_cmdv) begin
                    cmd_wait++;
                end
                if (p_beat) begin
                    m_beats++;
                    if (m_beats == BLOCK_WORDS) m_active = 1'b0;
                end
            end
            case (mem_mode)
                0:       begin cr = 1'b1; go = 1'b1; end
                1:       begin cr = 1'b1; go = (cyc_r % 2) == 0; end
                2:       begin cr = 1'($urandom_range(0, 1)); go = 1'($urandom_range(0, 1)); end
                default: begin cr = (cmd_wait >= 5); go = 1'b1; end
            endcase
            i_mem_cmd_ready = cr;
            // Outside a read, mode 2 also throws in stray rvalids that must be ignored.
            i_mem_rvalid = (m_active && !m_we) ? go
                         : (mem_mode == 2 && $urandom_range(0, 1) == 1);
            i_mem_rdata  = (m_active && !m_we) ? mem_word(m_addr, m_beats) : $urandom();
            i_mem_wready = go;
            #3;
            p_cmdv = o_mem_cmd_valid;
            p_cmd  = o_mem_cmd_valid && i_mem_cmd_ready;
            p_we   = o_mem_we;
            p_addr = o_mem_addr;
            p_beat = o_icache_rvalid || o_dcache_rvalid || (o_mem_wvalid && i_mem_wready);
        end
    end

    task automatic test_reset();
        @(posedge i_clk); #1;
        i_arst = 1'b1; i_icache_req = 1'b0; i_dcache_req = 1'b0;
        repeat (2) @(posedge i_clk);
        #3;
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", all_outs);
        end
        @(posedge i_clk); #2;
        i_arst = 1'b0;
        m_last_d = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_tests++;
            if (all_outs !== '0) begin
                n_fail++;
                $display("FAIL idle_outputs: cycle %0d got %h, want 0", k, all_outs);
            end
            @(posedge i_clk); #2;
        end
    endtask

    // One arbitration round: the chosen caches raise requests together from idle,
    // the model predicts the service order, and every beat is checked.
    task automatic test_round(input bit ri, input bit rd, input bit dwe, input int mode);
        bit          exp_d[$];
        logic [63:0] ia, da, held_addr, exp_a;
        logic [31:0] exp_rd;
        logic        held_we, cur_d, prev_cmdv, drop_i, drop_d, noisy;
        int          cyc, cmd_n, done_n, beats, cmd_cyc, done_cyc, stall, exp_cyc;
        if (ri && rd) begin
            exp_d.push_back(!m_last_d);
            exp_d.push_back(m_last_d);
        end else begin
            exp_d.push_back(rd);
            m_last_d = rd;
        end
        ia = {$urandom(), $urandom()};
        da = {$urandom(), $urandom()};
        mem_mode = mode;
        cur_d = 1'b0; held_addr = '0; held_we = 1'b0; noisy = 1'b0;
        cyc = 0; cmd_n = 0; done_n = 0; beats = 0; cmd_cyc = 0; done_cyc = 0; stall = 0;
        prev_cmdv = 1'b0; drop_i = 1'b0; drop_d = 1'b0;
        @(posedge i_clk); #1;
        i_icache_addr = ia; i_dcache_addr = da; i_dcache_we = dwe;
        i_icache_req = ri; i_dcache_req = rd;
        while (cyc < 400) begin
            #2;
            if (o_mem_cmd_valid && !prev_cmdv) begin
                n_tests++;
                if (cmd_n >= exp_d.size()) begin
                    n_fail++;
                    $display("FAIL extra_cmd: command at cycle %0d, want none", cyc);
                end else begin
                    cur_d = exp_d[cmd_n];
                    exp_a = align(cur_d ? da : ia);
                    if (o_mem_addr !== exp_a || o_mem_we !== (cur_d && dwe)) begin
                        n_fail++;
                        $display("FAIL cmd_fields: got addr %h we %b, want addr %h we %b",
                                 o_mem_addr, o_mem_we, exp_a, cur_d && dwe);
                    end
                    exp_cyc = (cmd_n == 0) ? 1 : done_cyc + 2;
                    n_tests++;
                    if (cyc != exp_cyc) begin
                        n_fail++;
                        $display("FAIL cmd_latency: got cycle %0d, want %0d", cyc, exp_cyc);
                    end
                end
                cmd_n++; beats = 0; cmd_cyc = cyc; stall = 0;
                held_addr = o_mem_addr; held_we = o_mem_we;
            end else if (o_mem_cmd_valid) begin
                n_tests++;
                if (o_mem_addr !== held_addr || o_mem_we !== held_we) begin
                    n_fail++;
                    $display("FAIL cmd_stable: got addr %h we %b, want addr %h we %b",
                             o_mem_addr, o_mem_we, held_addr, held_we);
                end
            end
            if (o_mem_cmd_valid && !i_mem_cmd_ready) stall++;
            if (o_mem_cmd_valid && i_mem_cmd_ready && mode == 3) begin
                n_tests++;
                if (stall != 5) begin
                    n_fail++;
                    $display("FAIL cmd_stall_cycles: got %0d, want 5", stall);
                end
            end
            if (o_mem_cmd_valid && (o_icache_rvalid || o_dcache_rvalid || o_mem_wvalid)) noisy = 1'b1;
            if (o_icache_rvalid || o_dcache_rvalid) begin
                n_tests++;
                exp_rd = mem_word(align(cur_d ? da : ia), beats);
                if ({o_icache_rvalid, o_dcache_rvalid} !== {!cur_d, cur_d} || (cur_d && dwe) ||
                    o_beat_idx !== 4'(beats) || o_rdata !== exp_rd) begin
                    n_fail++;
                    $display("FAIL read_beat: got irv %b drv %b idx %0d data %h, want irv %b drv %b idx %0d data %h",
                             o_icache_rvalid, o_dcache_rvalid, o_beat_idx, o_rdata,
                             !cur_d, cur_d, beats, exp_rd);
                end
                beats++;
            end
            if (o_mem_wvalid && i_mem_wready) begin
                n_tests++;
                if (!(cur_d && dwe) || o_beat_idx !== 4'(beats) ||
                    o_mem_wdata !== wr_word(da, 4'(beats))) begin
                    n_fail++;
                    $display("FAIL write_beat: got idx %0d data %h, want idx %0d data %h (write owner %b)",
                             o_beat_idx, o_mem_wdata, beats, wr_word(da, 4'(beats)), cur_d && dwe);
                end
                beats++;
            end
            if (o_icache_done || o_dcache_done) begin
                n_tests++;
                if ({o_icache_done, o_dcache_done} !== {!cur_d, cur_d} || beats != BLOCK_WORDS ||
                    (mode == 0 && cyc != cmd_cyc + 17)) begin
                    n_fail++;
                    $display("FAIL done_pulse: got idone %b ddone %b beats %0d cycle %0d, want idone %b ddone %b beats %0d",
                             o_icache_done, o_dcache_done, beats, cyc - cmd_cyc, !cur_d, cur_d, BLOCK_WORDS);
                end
                done_n++; done_cyc = cyc;
                if (o_icache_done) drop_i = 1'b1;
                if (o_dcache_done) drop_d = 1'b1;
            end
            prev_cmdv = o_mem_cmd_valid;
            if (done_n >= exp_d.size()) break;
            @(posedge i_clk); #1;
            cyc++;
            if (drop_i) begin i_icache_req = 1'b0; drop_i = 1'b0; end
            if (drop_d) begin i_dcache_req = 1'b0; drop_d = 1'b0; end
        end
        n_tests++;
        if (done_n != exp_d.size() || noisy) begin
            n_fail++;
            $display("FAIL round_complete: got %0d done pulses (beat during cmd %b), want %0d",
                     done_n, noisy, exp_d.size());
        end
        @(posedge i_clk); #1;
        i_icache_req = 1'b0; i_dcache_req = 1'b0;
        noisy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            if (o_mem_cmd_valid || o_icache_done || o_dcache_done || o_icache_rvalid ||
                o_dcache_rvalid || o_mem_wvalid) noisy = 1'b1;
            @(posedge i_clk); #1;
        end
        n_tests++;
        if (noisy) begin
            n_fail++;
            $display("FAIL round_quiet: got activity after final done, want none");
        end
    endtask

    task automatic test_i_refill();
        test_round(1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_d_writeback();
        test_round(1'b0, 1'b1, 1'b1, 1);
    endtask

    task automatic test_both();
        test_reset();
        test_round(1'b1, 1'b1, 1'b0, 0);   // last grant I: D served first
        test_round(1'b0, 1'b1, 1'b0, 0);   // D alone, last grant becomes D
        test_round(1'b1, 1'b1, 1'b1, 0);   // tie now goes to I
    endtask

    task automatic test_cmd_stall();
        test_round(1'b1, 1'b0, 1'b0, 3);
        test_round(1'b0, 1'b1, 1'b1, 3);
    endtask

    task automatic test_reset_mid();
        logic [63:0] ia;
        int          cyc, beats, cmd_cyc;
        bit          got_done;
        mem_mode = 0;
        ia = {$urandom(), $urandom()};
        @(posedge i_clk); #1;
        i_icache_addr = ia; i_icache_req = 1'b1;
        cyc = 0;
        while (cyc < 40) begin
            #2;
            if (o_icache_rvalid && o_beat_idx == 4'd7) break;
            @(posedge i_clk); #1;
            cyc++;
        end
        n_tests++;
        if (cyc >= 40) begin
            n_fail++;
            $display("FAIL reset_mid_beat7: got no beat 7 in 40 cycles, want one");
        end
        i_arst = 1'b1;
        #1;
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h, want 0", all_outs);
        end
        @(posedge i_clk); #2;
        i_arst = 1'b0;
        m_last_d = 1'b0;
        #1;
        n_tests++;
        if (all_outs !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: got %h, want 0", all_outs);
        end
        cyc = 0; beats = 0; cmd_cyc = -1; got_done = 1'b0;
        while (!got_done && cyc < 40) begin
            @(posedge i_clk); #3;
            cyc++;
            if (o_mem_cmd_valid && cmd_cyc < 0) cmd_cyc = cyc;
            if (o_icache_rvalid) begin
                n_tests++;
                if (o_beat_idx !== 4'(beats) || o_rdata !== mem_word(align(ia), beats)) begin
                    n_fail++;
                    $display("FAIL restart_beat: got idx %0d data %h, want idx %0d data %h",
                             o_beat_idx, o_rdata, beats, mem_word(align(ia), beats));
                end
                beats++;
            end
            if (o_icache_done) begin
                got_done = 1'b1;
                n_tests++;
                if (beats != BLOCK_WORDS || cmd_cyc != 1 || cyc != 18) begin
                    n_fail++;
                    $display("FAIL restart_done: got beats %0d cmd cycle %0d done cycle %0d, want 16 1 18",
                             beats, cmd_cyc, cyc);
                end
            end
        end
        n_tests++;
        if (!got_done) begin
            n_fail++;
            $display("FAIL restart_timeout: got no done in 40 cycles, want one");
        end
        @(posedge i_clk); #1;
        i_icache_req = 1'b0;
        repeat (2) @(posedge i_clk);
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 20; k++) begin
            r = $urandom_range(1, 3);
            test_round(r[0], r[1], 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
    endtask

    initial begin
        i_arst = 1'b1;
        i_icache_req = 1'b0; i_icache_addr = '0;
        i_dcache_req = 1'b0; i_dcache_we = 1'b0; i_dcache_addr = '0;
        test_reset();
        test_i_refill();
        test_d_writeback();
        test_both();
        test_cmd_stall();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the I-cache refill engine and the D-cache refill/write-back engine.
- Arbitrates between pending block requests and sequences the command phase and the BLOCK_WORDS data beats.
- Returns a one-cycle completion pulse to the winning requester.
- Caches hold their request level while waiting; the cache stall lines feeding the hazard unit (i_stall_i / i_stall_d) stay asserted until the matching done pulse.

Parameters:
- ADDR_W, 64, byte address width.
- DATA_W, 32, width of one data beat.
- BLOCK_WORDS, 16, beats per block transfer; power of two, at least 2.

Ports:
- i_clk  in  1  clock.
- i_arst  in  1  reset, asynchronous, active-high.
- i_icache_req  in  1  I-cache block read request; level, held until o_icache_done.
- i_icache_addr  in  ADDR_W  I-cache block address.
- o_icache_rvalid  out  1  read beat valid toward the I-cache.
- o_icache_done  out  1  one-cycle completion pulse to the I-cache.
- i_dcache_req  in  1  D-cache request; level, held until o_dcache_done.
- i_dcache_we  in  1  1 = write-back, 0 = refill.
- i_dcache_addr  in  ADDR_W  D-cache block address.
- i_dcache_wdata  in  DATA_W  write word for beat o_beat_idx.
- o_dcache_rvalid  out  1  read beat valid toward the D-cache.
- o_dcache_done  out  1  one-cycle completion pulse to the D-cache.
- o_rdata  out  DATA_W  read beat data, shared by both caches.
- o_beat_idx  out  $clog2(BLOCK_WORDS)  current beat index.
- o_mem_cmd_valid  out  1  command valid.
- i_mem_cmd_ready  in  1  command accepted.
- o_mem_we  out  1  command is a write.
- o_mem_addr  out  ADDR_W  block-aligned command address.
- i_mem_rvalid  in  1  read beat from memory.
- i_mem_rdata  in  DATA_W  read beat data.
- o_mem_wvalid  out  1  write beat valid.
- o_mem_wdata  out  DATA_W  write beat data.
- i_mem_wready  in  1  write beat accepted.

Behaviour:
- FSM states: IDLE, CMD, READ, WRITE, RESP.
- Reset: state IDLE, grant register = I, last_grant = I, beat counter 0. All outputs 0; o_mem_addr and o_rdata are 0.
- IDLE, arbitration:
  - Only I requesting: grant I. Only D requesting: grant D.
  - Both requesting: grant D, unless last_grant = D, then grant I (alternation).
  - On a grant: latch owner, address (low $clog2(BLOCK_WORDS*DATA_W/8) bits zeroed) and we (I forced to 0); update last_grant; go to CMD.
  - Requests are sampled only in IDLE; a request arriving in any other state waits.
- CMD:
  - o_mem_cmd_valid=1; o_mem_addr and o_mem_we are held stable until i_mem_cmd_ready.
  - On ready: go to READ if we=0, else WRITE. Counter cleared.
- READ:
  - o_rdata = i_mem_rdata combinationally.
  - The owner's rvalid = i_mem_rvalid; the other cache's rvalid stays 0.
  - o_beat_idx = counter. Counter increments per rvalid beat.
  - When rvalid arrives with counter = BLOCK_WORDS-1, go to RESP.
- WRITE:
  - o_mem_wvalid=1, o_mem_wdata = i_dcache_wdata, o_beat_idx = counter.
  - Counter increments on wvalid & wready.
  - When the accepted beat has counter = BLOCK_WORDS-1, go to RESP.
  - The D-cache must present the word for o_beat_idx combinationally.
- RESP: the owner's done = 1 for exactly one cycle, then IDLE. The earliest next grant is the cycle after RESP.
- Latency, zero memory wait: IDLE→CMD 1 cycle, CMD 1 cycle, BLOCK_WORDS beat cycles, RESP 1 cycle; done pulse in cycle BLOCK_WORDS+2 after the request is seen in IDLE.
- Counter is $clog2(BLOCK_WORDS) bits and is never compared past BLOCK_WORDS-1; no wrap-around occurs within a transfer.
- A request dropped mid-transfer is not legal; the arbiter completes the transfer regardless.
- i_mem_rvalid outside READ and i_mem_wready outside WRITE are ignored.
- Async reset mid-transfer: immediate return to reset values; the transfer is abandoned and no done pulse is issued.

Test Plan:
- I-only refill, memory always ready, BLOCK_WORDS=16 → o_mem_addr = addr & ~63, o_mem_we=0, 16 o_icache_rvalid beats with idx 0..15, o_icache_done at cycle 18, o_dcache_rvalid never set.
- D write-back, i_mem_wready toggling 1/0 → exactly 16 accepted beats, o_mem_wdata matches the D-cache word per idx, one o_dcache_done, then IDLE.
- I and D both requesting in the same cycle from reset (last_grant=I) → D granted first; I granted in the IDLE after D's RESP; a further D request next time loses to I alternation only if last_grant=D.
- i_mem_cmd_ready held 0 for 5 cycles → o_mem_cmd_valid, o_mem_addr, o_mem_we stable for all 5 cycles, no beat counted.
- i_arst pulsed during beat 7 of a read → all outputs 0 asynchronously, no done pulse; the held request restarts with a fresh CMD at beat 0.
